// File: rtl/mem_copy_dma.sv
// Block-copy DMA initiator on the data-memory port: alternating read/write, one word at a time.
// Optional DMA_FILL_EN adds a write-only fill mode (fill_en/fill_value latched with start).
module mem_copy_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        length,
`ifdef DMA_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [7:0]        len_q, cnt;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] cnt_a;
    logic              last;
    logic              accept;
    logic              fill_go, fill_run;
    logic [DATA_W-1:0] wdata_src;

    assign cnt_a  = ADDR_W'(cnt);
    assign last   = (cnt == len_q - 8'd1);
    assign accept = (state == IDLE) && start && (length != 8'd0);

`ifdef DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (accept) begin
            fill_q     <= fill_en;
            fill_val_q <= fill_value;
        end
    end

    assign fill_go   = fill_en;
    assign fill_run  = fill_q;
    assign wdata_src = fill_q ? fill_val_q : data_q;
`else
    assign fill_go   = 1'b0;
    assign fill_run  = 1'b0;
    assign wdata_src = data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs decode purely from registered state so the memory port never sees input glitches.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        address   = '0;
        writedata = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (length == 8'd0) state_nxt = DONE;
                    else                state_nxt = fill_go ? WRITE : READ;
                end
            end
            READ: begin
                memread   = 1'b1;
                address   = src_q + cnt_a;
                state_nxt = WRITE;
            end
            WRITE: begin
                memwrite  = 1'b1;
                address   = dst_q + cnt_a;
                writedata = wdata_src;
                if (last)          state_nxt = DONE;
                else if (fill_run) state_nxt = WRITE;
                else               state_nxt = READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= length;
                cnt   <= '0;
            end
            if (state == READ)  data_q <= readdata;
            if (state == WRITE) cnt    <= cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: bus-op scoreboard plus memory/model comparison.
module tb_mem_copy_dma;

    logic       clk, rst_n, start;
    logic [7:0] src_addr, dst_addr, length;
    logic       busy, done, memread, memwrite;
    logic [7:0] address, writedata, readdata;
`ifdef DMA_FILL_EN
    logic       fill_en;
    logic [7:0] fill_value;
`endif

    mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef DMA_FILL_EN
        .fill_en(fill_en), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .memread(memread), .memwrite(memwrite),
        .address(address), .writedata(writedata), .readdata(readdata)
    );

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    logic [7:0] mem   [256];
    logic [7:0] model [256];
    op_t        exp_q [$];
    int         checks = 0;
    int         errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign readdata = mem[address];
    always @(posedge clk) if (memwrite) mem[address] <= writedata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every strobe must match the next expected op; idle bus must be all zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memread || memwrite) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op", exp_q.size(), 1);
                end else begin
                    op_t e;
                    e = exp_q.pop_front();
                    chk("op_kind", memwrite, e.wr);
                    chk("op_excl", memread & memwrite, 0);
                    chk("op_addr", address, e.addr);
                    if (e.wr) chk("op_data", writedata, e.data);
                end
            end else begin
                chk("idle_addr", address, 0);
                chk("idle_wdata", writedata, 0);
            end
        end
    end

    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input bit fl, input logic [7:0] fv, input int glitch,
                            input int exp_done);
        int k;
        logic [7:0] v;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        for (int i = 0; i < l; i++) begin
            if (fl) v = fv;
            else begin
                v = model[8'(s + i)];
                exp_q.push_back('{1'b0, 8'(s + i), 8'h00});
            end
            exp_q.push_back('{1'b1, 8'(d + i), v});
            model[8'(d + i)] = v;
        end
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
`ifdef DMA_FILL_EN
        fill_en = fl; fill_value = fv;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == glitch) begin
                start = 1'b1; src_addr = 8'h40; dst_addr = 8'h90; length = 8'd7;
            end else start = 1'b0;
            if (!done) chk("busy_xfer", busy, 1);
        end while (!done && k < 600);
        chk("done_cycle", k, exp_done);
        chk("done_busy", busy, 1);
        chk("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < l; i++) chk("mem_dst", mem[8'(d + i)], model[8'(d + i)]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
`ifdef DMA_FILL_EN
        fill_en = 1'b0; fill_value = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'(i) ^ 8'h5C;
            model[i] = 8'(i) ^ 8'h5C;
        end
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
        model[8'h10] = 8'hA1; model[8'h11] = 8'hB2; model[8'h12] = 8'hC3; model[8'h13] = 8'hD4;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", memread, 0);
        chk("rst_wr", memwrite, 0);
        chk("rst_addr", address, 0);
        chk("rst_wdata", writedata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 0, 9);   // basic copy
        run_xfer(8'h10, 8'h80, 8'd0, 1'b0, 8'h00, 0, 1);   // zero length no-op
        chk("len0_mem", mem[8'h80], 8'hA1);
        run_xfer(8'hFE, 8'h01, 8'd3, 1'b0, 8'h00, 0, 7);   // address wrap
        run_xfer(8'h20, 8'hC0, 8'd4, 1'b0, 8'h00, 3, 9);   // start ignored while busy
        chk("glitch_untouched", mem[8'h90], model[8'h90]);
        run_xfer(8'h30, 8'h31, 8'd3, 1'b0, 8'h00, 0, 7);   // overlapping propagate
        chk("overlap_val", mem[8'h33], 8'h30 ^ 8'h5C);
        run_xfer(8'h60, 8'hE0, 8'd1, 1'b0, 8'h00, 0, 3);   // single word
`ifdef DMA_FILL_EN
        run_xfer(8'h00, 8'h20, 8'd3, 1'b1, 8'h5A, 0, 4);   // fill mode
        fill_en = 1'b0;
`endif

        // Reset during WRITE of word 2 of a 5-word copy.
        @(negedge clk);
        chk("pre_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b0, 8'(8'h50 + i), 8'h00});
            exp_q.push_back('{1'b1, 8'(8'hA0 + i), model[8'(8'h50 + i)]});
            if (i < 2) model[8'(8'hA0 + i)] = model[8'(8'h50 + i)];
        end
        src_addr = 8'h50; dst_addr = 8'hA0; length = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd", memread, 0);
        chk("abort_wr", memwrite, 0);
        chk("abort_addr", address, 0);
        chk("abort_wdata", writedata, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_done", done, 0);
            chk("abort_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
        end
        chk("abort_queue", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) chk("abort_mem", mem[8'(8'hA0 + i)], model[8'(8'hA0 + i)]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
